// File: rtl/router_pkg.sv
// Shared defaults and entry layout for the router output FIFO.
// Each stored entry is a data byte tagged with a header-marker bit.
package router_pkg;

  localparam int ROUTER_WIDTH   = 8;
  localparam int ROUTER_DEPTH   = 16;
  localparam int ROUTER_TIMEOUT = 30;

  typedef struct packed {
    logic                    hdr;
    logic [ROUTER_WIDTH-1:0] data;
  } entry_t;

  // Bytes still to pop after a header: payload length plus the parity byte.
  function automatic logic [6:0] pkt_remaining(input logic [ROUTER_WIDTH-1:0] hdr_byte);
    return {1'b0, hdr_byte[7:2]} + 7'd1;
  endfunction

endpackage

// File: rtl/router_timeout_wdog.sv
// Watchdog for an unserviced output port: counts consecutive cycles with data
// waiting and no read, and requests a flush on the TIMEOUT-th such edge.
module router_timeout_wdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld_out,
  input  logic read_enb,
  output logic flush,
  output logic soft_reset
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] idle_cnt_reg;
  logic          soft_reset_reg;
  logic          idle;

  assign idle       = vld_out && !read_enb;
  assign flush      = idle && (idle_cnt_reg == CW'(TIMEOUT - 1));
  assign soft_reset = soft_reset_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_reg   <= '0;
      soft_reset_reg <= 1'b0;
    end else begin
      soft_reset_reg <= flush;
      if (!idle || flush) idle_cnt_reg <= '0;
      else                idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/router_out_fifo.sv
// Per-port output buffer of the 1x3 router: header-tagged FIFO with registered
// read data, packet-end tracking and a timeout-driven flush.
module router_out_fifo
  import router_pkg::*;
#(
  parameter int WIDTH   = ROUTER_WIDTH,
  parameter int DEPTH   = ROUTER_DEPTH,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  output logic             full,
  output logic             empty,
  output logic             eop,
  output logic             soft_reset
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        popped;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [6:0]    byte_cnt_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic          eop_reg;
  logic          flush;
  logic          wr_acc, rd_acc;

  assign full     = (count_reg == (PW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign vld_out  = !empty;
  assign data_out = data_out_reg;
  assign eop      = eop_reg;

  // full/empty are sampled before the edge, so a pop never frees room for a
  // same-cycle push and a push never feeds a same-cycle pop.
  assign wr_acc = write_enb && !full  && !flush;
  assign rd_acc = read_enb  && !empty && !flush;
  assign popped = mem[rd_ptr_reg];

  router_timeout_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out    (vld_out),
    .read_enb   (read_enb),
    .flush      (flush),
    .soft_reset (soft_reset)
  );

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr_reg] <= '{hdr: lfd_state, data: data_in};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      byte_cnt_reg <= '0;
      data_out_reg <= '0;
      eop_reg      <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      byte_cnt_reg <= '0;
      data_out_reg <= '0;
      eop_reg      <= 1'b0;
    end else begin
      eop_reg <= 1'b0;
      if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_acc) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        data_out_reg <= popped.data;
        if (popped.hdr) begin
          byte_cnt_reg <= pkt_remaining(popped.data);
        end else if (byte_cnt_reg != '0) begin
          byte_cnt_reg <= byte_cnt_reg - 1'b1;
          eop_reg      <= (byte_cnt_reg == 7'd1);
        end
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_router_out_fifo.sv
// Directed bench for router_out_fifo: reset, fill/drain, framing,
// concurrent push/pop at full, timeout flush and watchdog clearing.
module tb_router_out_fifo;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       vld_out, full, empty, eop, soft_reset;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  router_out_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .vld_out    (vld_out),
    .full       (full),
    .empty      (empty),
    .eop        (eop),
    .soft_reset (soft_reset)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    write_enb = 1; data_in = 8'h55; step();
    write_enb = 0; read_enb = 1; step();
    read_enb = 0;
    checks++;
    if (data_out !== 8'h55) begin errors++; $display("FAIL pre_reset_data: got %h expected 55", data_out); end
    write_enb = 1; data_in = 8'h66; step();
    write_enb = 0;
    #3 resetn = 0;
    #1;
    checks++;
    if ({data_out, vld_out, empty, full, soft_reset, eop} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got d=%h v=%b e=%b f=%b sr=%b eop=%b expected d=00 v=0 e=1 f=0 sr=0 eop=0",
               data_out, vld_out, empty, full, soft_reset, eop);
    end
    repeat (3) @(posedge clock);
    @(negedge clock) resetn = 1;
    step();
    checks++;
    if ({vld_out, empty} !== 2'b01) begin errors++; $display("FAIL post_reset: got v=%b e=%b expected v=0 e=1", vld_out, empty); end
    $display("reset: done");
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      write_enb = 1; lfd_state = (i == 0); data_in = 8'(i); step();
      checks++;
      if (full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 15)); end
    end
    lfd_state = 0; data_in = 8'hAA; step();
    write_enb = 0;
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL overflow_full: got %b expected 1", full); end
    read_enb = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      $display("drain: pop data_out=%h eop=%b", data_out, eop);
      checks++;
      if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 8'(i)); end
      checks++;
      if (eop !== (i == 1)) begin errors++; $display("FAIL drain_eop[%0d]: got %b expected %b", i, eop, (i == 1)); end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    step();
    read_enb = 0;
    checks++;
    if (data_out !== 8'h0F) begin errors++; $display("FAIL read_empty_hold: got %h expected 0f", data_out); end
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h5A};
    for (int i = 0; i < 5; i++) begin
      write_enb = 1; lfd_state = (i == 0); data_in = pkt[i]; step();
    end
    write_enb = 0; lfd_state = 0; read_enb = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      $display("packet: pop data_out=%h eop=%b", data_out, eop);
      checks++;
      if (data_out !== pkt[i]) begin errors++; $display("FAIL pkt_data[%0d]: got %h expected %h", i, data_out, pkt[i]); end
      checks++;
      if (eop !== (i == 4)) begin errors++; $display("FAIL pkt_eop[%0d]: got %b expected %b", i, eop, (i == 4)); end
    end
    read_enb = 0; step();
    checks++;
    if (eop !== 1'b0) begin errors++; $display("FAIL pkt_eop_pulse: got %b expected 0", eop); end
  endtask

  task automatic test_concurrent_full();
    for (int i = 0; i < 16; i++) begin
      write_enb = 1; data_in = 8'h20 + 8'(i); step();
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL conc_full: got %b expected 1", full); end
    data_in = 8'hEE; read_enb = 1; step();
    write_enb = 0;
    checks++;
    if ({full, data_out} !== {1'b0, 8'h20}) begin errors++; $display("FAIL conc_pop: got f=%b d=%h expected f=0 d=20", full, data_out); end
    for (int i = 1; i < 16; i++) begin
      step();
      checks++;
      if (data_out !== 8'h20 + 8'(i)) begin errors++; $display("FAIL conc_drain[%0d]: got %h expected %h", i, data_out, 8'h20 + 8'(i)); end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL conc_empty: got %b expected 1", empty); end
    step();
    read_enb = 0;
    checks++;
    if (data_out !== 8'h2F) begin errors++; $display("FAIL conc_dropped: got %h expected 2f", data_out); end
  endtask

  task automatic test_timeout();
    write_enb = 1; data_in = 8'h77; step();
    write_enb = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++;
      if (soft_reset !== (k == 30)) begin errors++; $display("FAIL to_soft_reset[%0d]: got %b expected %b", k, soft_reset, (k == 30)); end
    end
    checks++;
    if ({empty, data_out} !== {1'b1, 8'h00}) begin errors++; $display("FAIL to_flush: got e=%b d=%h expected e=1 d=00", empty, data_out); end
    step();
    checks++;
    if ({soft_reset, empty, vld_out} !== 3'b010) begin
      errors++; $display("FAIL to_after: got sr=%b e=%b v=%b expected sr=0 e=1 v=0", soft_reset, empty, vld_out);
    end
    $display("timeout: soft_reset pulse seen");
  endtask

  task automatic test_wdog_clear();
    logic [7:0] wb [3] = '{8'h31, 8'h32, 8'h33};
    for (int i = 0; i < 3; i++) begin
      write_enb = 1; data_in = wb[i]; step();
    end
    write_enb = 0;
    for (int k = 0; k < 27; k++) begin
      step();
      checks++;
      if (soft_reset !== 1'b0) begin errors++; $display("FAIL wd_idle[%0d]: got %b expected 0", k, soft_reset); end
    end
    read_enb = 1; step();
    read_enb = 0;
    checks++;
    if ({soft_reset, data_out} !== {1'b0, 8'h31}) begin errors++; $display("FAIL wd_read: got sr=%b d=%h expected sr=0 d=31", soft_reset, data_out); end
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++;
      if (soft_reset !== (k == 30)) begin errors++; $display("FAIL wd_soft_reset[%0d]: got %b expected %b", k, soft_reset, (k == 30)); end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL wd_empty: got %b expected 1", empty); end
    write_enb = 1; data_in = 8'h44; step();
    write_enb = 0; read_enb = 1; step();
    read_enb = 0;
    checks++;
    if ({data_out, empty} !== {8'h44, 1'b1}) begin errors++; $display("FAIL post_flush: got d=%h e=%b expected d=44 e=1", data_out, empty); end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1;
    test_reset();
    test_fill_drain();
    test_packet();
    test_concurrent_full();
    test_timeout();
    test_wdog_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
